// File: rtl/freq_meter.sv
// Measures the period and high time of an asynchronous square wave in CLK
// cycles, one measurement per START, aborting with TIMEOUT on a dead input.
module freq_meter #(
  parameter int          CntW       = 16,
  parameter int unsigned Timeout    = 50_000,
  parameter int          SyncStages = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            SIG_In,
  input  logic            START,
  output logic            BUSY,
  output logic            VALID,
  output logic            TIMEOUT,
  output logic [CntW-1:0] PERIOD,
  output logic [CntW-1:0] HIGH
);

  // state   | meaning
  // S_IDLE  | waiting for START
  // S_ARM   | waiting for the first rise
  // S_HIGH  | signal high, counting period and high time
  // S_LOW   | signal low, counting period
  // S_DONE  | results presented, VALID pulse
  typedef enum logic [2:0] {S_IDLE, S_ARM, S_HIGH, S_LOW, S_DONE} state_t;

  localparam logic [CntW-1:0] TmoLast = CntW'(Timeout - 1);

  state_t                state_q, state_d;
  logic [SyncStages-1:0] sync_q;
  logic                  prev_q;
  logic [CntW-1:0]       tmo_q, tmo_d;
  logic [CntW-1:0]       per_q, per_d;
  logic [CntW-1:0]       hic_q, hic_d;
  logic [CntW-1:0]       hi_lat_q, hi_lat_d;
  logic [CntW-1:0]       period_q, period_d;
  logic [CntW-1:0]       high_q, high_d;
  logic                  tout_q, tout_d;

  logic sig_s, rise, fall, measuring;

  assign sig_s     = sync_q[SyncStages-1];
  assign rise      = sig_s & ~prev_q;
  assign fall      = ~sig_s & prev_q;
  assign measuring = (state_q == S_ARM) || (state_q == S_HIGH) || (state_q == S_LOW);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], SIG_In};
      prev_q <= sig_s;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      tmo_q    <= '0;
      per_q    <= '0;
      hic_q    <= '0;
      hi_lat_q <= '0;
      period_q <= '0;
      high_q   <= '0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      per_q    <= per_d;
      hic_q    <= hic_d;
      hi_lat_q <= hi_lat_d;
      period_q <= period_d;
      high_q   <= high_d;
      tout_q   <= tout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    per_d    = per_q;
    hic_d    = hic_q;
    hi_lat_d = hi_lat_q;
    period_d = period_q;
    high_d   = high_q;
    tout_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_ARM;
          tmo_d   = '0;
        end
      end
      S_ARM: begin
        if (rise) begin
          state_d = S_HIGH;
          per_d   = CntW'(1);
          hic_d   = CntW'(1);
        end
      end
      S_HIGH: begin
        per_d = per_q + 1'b1;
        hic_d = hic_q + 1'b1;
        if (fall) begin
          hi_lat_d = hic_q;
          state_d  = S_LOW;
        end
      end
      S_LOW: begin
        per_d = per_q + 1'b1;
        if (rise) begin
          period_d = per_q;
          high_d   = hi_lat_q;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // An edge in the expiry cycle restarts the watchdog instead of aborting.
    if (measuring) begin
      if (rise || fall) begin
        tmo_d = '0;
      end else if (tmo_q == TmoLast) begin
        state_d = S_IDLE;
        tout_d  = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  assign BUSY    = measuring;
  assign VALID   = (state_q == S_DONE);
  assign TIMEOUT = tout_q;
  assign PERIOD  = period_q;
  assign HIGH    = high_q;

endmodule
